uart_tx_sched: RTL and testbench

Synthesizable UART transmit scheduler. It shares one serial TX line between `NUM_REQ` byte producers using round-robin arbitration. It serializes each granted byte as an 8-bit LSB-first frame with one start bit, an optional even-parity bit and one stop bit. It sits in the UDMA verification environment between test stimulus sources (multiple channel drivers) and the RX line of a UART device or receive monitor. Parity is even: a receiver computing XOR of the data bits and the parity bit sees 0.

---
 rtl/uart_tb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/uart_tx_sched.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tb_pkg.sv
// Shared types and constants for the UART transmit scheduler.
//   uart_tx_state_e : frame FSM state encoding
//   UART_DATA_BITS  : payload bits per frame (LSB first)
//   UART_STOP_BITS  : stop bits per frame
package uart_tb_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index for this decision
//   en  : when low no grant is produced
//   gnt : one-hot grant (all zero when nothing granted)
//   idx : encoded index of the granted requester
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic found;
    int   cand;

    // Walk the requesters starting at ptr, wrapping; first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            if (en && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: shares one TX line between NUM_REQ byte
// producers with round-robin arbitration. Frame = start(0), 8 data bits
// LSB first, optional even parity, stop(1); each bit lasts div_q+1 clocks.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   cfg_en_i      : allows new grants (an active frame always completes)
//   cfg_div_i     : clocks per bit minus 1, sampled at grant
//   req_valid_i   : per-requester byte valid
//   req_data_i    : per-requester byte, requester i at [8i+7:8i]
//   req_ready_o   : one-hot accept strobe
//   tx_o          : serial line, idle high
//   busy_o        : frame in progress
//   grant_id_o    : requester of the current or last frame
//   frame_done_o  : one-cycle pulse on the last stop-bit cycle
//
// Handshake: a byte moves when req_valid_i[i] and req_ready_o[i] are both
// high in the same cycle. req_ready_o is only raised in IDLE, is at most
// one-hot, and never depends on a requester that is not valid.
module uart_tx_sched
    import uart_tb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DIV_WIDTH = 16,
    parameter int PARITY_EN = 1,
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_en_i,
    input  logic [DIV_WIDTH-1:0]   cfg_div_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic [IDX_W-1:0]       grant_id_o,
    output logic                   frame_done_o
);

    uart_tx_state_e       state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           data_q, data_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     gid_q, gid_d;
    logic                 tx_q, tx_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_en;
    logic                 bit_last;

    // Grants only from IDLE and never while reset is asserted, so the
    // accept strobe stays low during reset even with requests pending.
    assign arb_en   = cfg_en_i && (state_q == ST_IDLE) && !rst_i;
    assign bit_last = (cnt_q == div_q);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req (req_valid_i),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // State register (tx_q resets high so the line idles immediately).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic, including bit-period counter and bit index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    div_d   = cfg_div_i;
                    gid_d   = arb_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_gnt[i]) data_d = req_data_i[i*8 +: 8];
                    end
                    if (int'(arb_idx) == NUM_REQ - 1) ptr_d = '0;
                    else                              ptr_d = arb_idx + IDX_W'(1);
                end
            end
            ST_START: begin
                if (bit_last) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    cnt_d = '0;
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_last) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs. tx_d is the line level for the *next* cycle, derived from
    // the next state so tx_o falls on the cycle right after the grant.
    always_comb begin
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_d[bit_d];
            ST_PARITY: tx_d = ^data_d;
            default:   tx_d = 1'b1;
        endcase
        busy_o       = (state_q != ST_IDLE);
        req_ready_o  = arb_gnt;
        frame_done_o = (state_q == ST_STOP) && bit_last;
    end

    assign tx_o       = tx_q;
    assign grant_id_o = gid_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  req_ready_o;
    logic        tx_o, busy_o, frame_done_o;
    logic [1:0]  grant_id_o;

    logic        valid_b;
    logic [7:0]  data_b;
    logic        ready_b, tx_b, busy_b, done_b;
    logic        gid_b;

    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(4), .DIV_WIDTH(16), .PARITY_EN(1)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .cfg_en_i(cfg_en), .cfg_div_i(cfg_div),
        .req_valid_i(valid), .req_data_i(data), .req_ready_o(req_ready_o),
        .tx_o(tx_o), .busy_o(busy_o), .grant_id_o(grant_id_o),
        .frame_done_o(frame_done_o)
    );

    uart_tx_sched #(.NUM_REQ(1), .DIV_WIDTH(16), .PARITY_EN(0)) u_dut_b (
        .clk_i(clk), .rst_i(rst_i), .cfg_en_i(cfg_en), .cfg_div_i(cfg_div),
        .req_valid_i(valid_b), .req_data_i(data_b), .req_ready_o(ready_b),
        .tx_o(tx_b), .busy_o(busy_b), .grant_id_o(gid_b),
        .frame_done_o(done_b)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each grant expands the frame into a per-cycle list of expected line
    // levels; while that list is non-empty the line is busy.
    typedef struct packed { logic tx; logic done; } slot_t;
    slot_t fq[$];
    int    m_ptr = 0;
    int    m_gid = 0;

    task automatic push_frame(input logic [7:0] d, input int div);
        logic  b[$];
        slot_t s;
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        b.push_back(^d);
        b.push_back(1'b1);
        for (int i = 0; i < b.size(); i++)
            for (int k = 0; k <= div; k++) begin
                s.tx   = b[i];
                s.done = (i == b.size() - 1) && (k == div);
                fq.push_back(s);
            end
    endtask

    always @(negedge clk) begin : compare
        logic [8:0] exp_v, act_v;
        logic [3:0] rdy;
        slot_t      s;
        int         g;
        act_v = {tx_o, busy_o, frame_done_o, req_ready_o, grant_id_o};
        if (rst_i) begin
            fq.delete();
            m_ptr = 0;
            m_gid = 0;
            exp_v = {1'b1, 1'b0, 1'b0, 4'b0000, 2'd0};
        end else if (fq.size() > 0) begin
            s = fq.pop_front();
            exp_v = {s.tx, 1'b1, s.done, 4'b0000, 2'(m_gid)};
        end else begin
            g = -1;
            if (cfg_en)
                for (int off = 0; off < 4; off++)
                    if (g < 0 && valid[(m_ptr + off) % 4]) g = (m_ptr + off) % 4;
            rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
            exp_v = {1'b1, 1'b0, 1'b0, rdy, 2'(m_gid)};
            if (g >= 0) begin
                push_frame(data[g*8 +: 8], int'(cfg_div));
                m_gid = g;
                m_ptr = (g + 1) % 4;
            end
        end
        n_vec++;
        if (act_v !== exp_v) begin
            n_miss++;
            $display("FAIL model cyc=%0d {tx,busy,done,ready,gid}: got %b, want %b",
                     cyc, act_v, exp_v);
        end
    end

    // ---------------- event logs ----------------
    int gl_cyc[$], gl_idx[$], dl_cyc[$];

    always @(negedge clk) begin
        if (!rst_i) begin
            for (int i = 0; i < 4; i++)
                if (req_ready_o[i]) begin
                    gl_cyc.push_back(cyc);
                    gl_idx.push_back(i);
                end
            if (frame_done_o) dl_cyc.push_back(cyc);
        end
    end

    // ---------------- driver / helper tasks ----------------
    task automatic wait_ready(output int g);
        g = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (|req_ready_o) begin
                for (int i = 0; i < 4; i++) if (req_ready_o[i]) g = i;
                break;
            end
        end
        if (g < 0) begin
            n_vec++; n_miss++;
            $display("FAIL wait_ready: timeout, got no grant, want a grant");
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk); #1;
            if (!busy_o && !busy_b) return;
        end
        n_vec++; n_miss++;
        $display("FAIL wait_idle: timeout, got busy, want idle");
    endtask

    task automatic wait_log(input bit use_done, input int n, input string name);
        for (int k = 0; k < 800; k++) begin
            @(negedge clk); #1;
            if ((use_done ? dl_cyc.size() : gl_cyc.size()) >= n) return;
        end
        n_vec++; n_miss++;
        $display("FAIL %s: timeout, got fewer than %0d events, want %0d", name, n, n);
    endtask

    // Receive-side monitor: find the start bit, then sample mid-bit.
    task automatic uart_rx(input bit which, input int bc, input bit par,
                           output logic [7:0] d, output logic pb,
                           output logic sb, output bit ok);
        ok = 1'b0; d = '0; pb = 1'b0; sb = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if ((which ? tx_b : tx_o) == 1'b0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_vec++; n_miss++;
            $display("FAIL uart_rx: timeout, got no start bit, want start bit");
            return;
        end
        repeat (bc / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (bc) @(negedge clk);
            d[i] = which ? tx_b : tx_o;
        end
        if (par) begin
            repeat (bc) @(negedge clk);
            pb = tx_o;
        end
        repeat (bc) @(negedge clk);
        sb = which ? tx_b : tx_o;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        int         g, len;
        bit         ok;
        logic [7:0] d;
        logic       pb, sb;
        logic [10:0] pat;
        logic [7:0] p2_byte [2];
        logic       p2_par  [2];
        int         rr_exp  [5];
        int         rr2_exp [3];

        rst_i = 1'b1; cfg_en = 1'b1; cfg_div = 16'd3;
        valid = '0; data = '0; valid_b = 1'b0; data_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk); #1;
        chk("reset_tx", tx_o, 1);
        chk("reset_busy", busy_o, 0);
        chk("reset_ready", req_ready_o, 0);
        chk("reset_done", frame_done_o, 0);
        chk("reset_gid", grant_id_o, 0);

        // Single frame: req2 sends 0x55 at 4 clocks per bit.
        pat = 11'b10010101010;   // bit k = line level during frame bit k
        @(posedge clk); #1;
        data[23:16] = 8'h55; valid = 4'b0100;
        wait_ready(g);
        chk("t1_grant", g, 2);
        @(posedge clk); #1 valid = '0;
        for (int k = 0; k < 44; k++) begin
            @(negedge clk); #1;
            chk("t1_tx", tx_o, pat[k / 4]);
            chk("t1_done", frame_done_o, (k == 43));
        end
        chk("t1_gid", grant_id_o, 2);
        wait_idle();

        // Parity from req3.
        p2_byte[0] = 8'h07; p2_par[0] = 1'b1;
        p2_byte[1] = 8'h00; p2_par[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            data[31:24] = p2_byte[t]; valid = 4'b1000;
            wait_ready(g);
            chk("t2_grant", g, 3);
            @(posedge clk); #1 valid = '0;
            uart_rx(1'b0, 4, 1'b1, d, pb, sb, ok);
            chk("t2_data", d, p2_byte[t]);
            chk("t2_parity", pb, p2_par[t]);
            chk("t2_stop", sb, 1);
            wait_idle();
        end

        // No-parity single-requester instance: 40-cycle frame.
        @(posedge clk); #1;
        data_b = 8'h07; valid_b = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (ready_b) begin ok = 1'b1; break; end
        end
        chk("b_ready_seen", ok, 1);
        @(posedge clk); #1 valid_b = 1'b0;
        fork
            uart_rx(1'b1, 4, 1'b0, d, pb, sb, ok);
            begin
                len = 0;
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk); len++;
                    if (done_b) break;
                end
            end
        join
        chk("b_len", len, 40);
        chk("b_data", d, 8'h07);
        chk("b_stop", sb, 1);
        chk("b_gid", gid_b, 0);
        wait_idle();

        // Round robin, all four valid.
        rr_exp = '{0, 1, 2, 3, 0};
        gl_cyc.delete(); gl_idx.delete();
        @(posedge clk); #1;
        data = 32'h44332211; valid = 4'b1111;
        wait_log(1'b0, 5, "t3_rr_wait");
        @(posedge clk); #1 valid = '0;
        chk("t3_rr_count", gl_idx.size(), 5);
        for (int i = 0; i < 5 && i < gl_idx.size(); i++) chk("t3_rr_order", gl_idx[i], rr_exp[i]);
        wait_idle();

        // Only req1 and req3 valid.
        rr2_exp = '{1, 3, 1};
        gl_cyc.delete(); gl_idx.delete();
        @(posedge clk); #1 valid = 4'b1010;
        wait_log(1'b0, 3, "t3_pair_wait");
        @(posedge clk); #1 valid = '0;
        for (int i = 0; i < 3 && i < gl_idx.size(); i++) chk("t3_pair_order", gl_idx[i], rr2_exp[i]);
        wait_idle();

        // Enable drops at data bit 4: frame completes, no new grant.
        @(posedge clk); #1;
        data[7:0] = 8'h3C; valid = 4'b0001;
        wait_ready(g);
        chk("t4a_grant", g, 0);
        repeat (21) @(negedge clk);
        @(posedge clk); #1 cfg_en = 1'b0;
        gl_cyc.delete(); gl_idx.delete(); dl_cyc.delete();
        repeat (80) @(negedge clk);
        #1;
        chk("t4a_no_grant", gl_idx.size(), 0);
        chk("t4a_done_count", dl_cyc.size(), 1);
        chk("t4a_idle", busy_o, 0);
        @(posedge clk); #1 valid = '0; cfg_en = 1'b1;

        // Divider change mid-frame applies at the next grant only.
        gl_cyc.delete(); gl_idx.delete(); dl_cyc.delete();
        @(posedge clk); #1;
        data[15:8] = 8'h96; valid = 4'b0010;
        wait_log(1'b0, 1, "t4b_g0");
        repeat (10) @(posedge clk);
        #1 cfg_div = 16'd7;
        wait_log(1'b0, 2, "t4b_g1");
        @(posedge clk); #1 valid = '0;
        wait_log(1'b1, 2, "t4b_d1");
        if (gl_cyc.size() >= 2 && dl_cyc.size() >= 2) begin
            chk("t4b_len0", dl_cyc[0] - gl_cyc[0], 44);
            chk("t4b_gap", gl_cyc[1] - gl_cyc[0], 45);
            chk("t4b_len1", dl_cyc[1] - gl_cyc[1], 88);
            chk("t4b_gid", gl_idx[1], 1);
        end
        wait_idle();
        @(posedge clk); #1 cfg_div = 16'd3;

        // Reset during DATA: line forced high without a clock edge.
        @(posedge clk); #1;
        data[23:16] = 8'hF0; valid = 4'b0100;
        wait_ready(g);
        chk("t5_grant", g, 2);
        @(posedge clk); #1 valid = '0;
        repeat (8) @(negedge clk);
        chk("t5_pre_tx", tx_o, 0);
        #2 rst_i = 1'b1;
        #1;
        chk("t5_async_tx", tx_o, 1);
        chk("t5_async_busy", busy_o, 0);
        chk("t5_async_done", frame_done_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0; valid = 4'b1111;
        wait_ready(g);
        chk("t5_after_reset", g, 0);
        @(posedge clk); #1 valid = '0;
        wait_idle();

        // Minimum divider, back-to-back frames from req0.
        gl_cyc.delete(); gl_idx.delete(); dl_cyc.delete();
        @(posedge clk); #1;
        cfg_div = 16'd0; data[7:0] = 8'hA3; valid = 4'b0001;
        for (int f = 0; f < 3; f++) begin
            uart_rx(1'b0, 1, 1'b1, d, pb, sb, ok);
            chk("t6_data", d, 8'hA3);
            chk("t6_parity_err", (^d) ^ pb, 0);
            chk("t6_stop", sb, 1);
        end
        @(posedge clk); #1 valid = '0;
        wait_idle();
        chk("t6_grants", (gl_cyc.size() >= 3), 1);
        if (gl_cyc.size() >= 3 && dl_cyc.size() >= 1) begin
            chk("t6_gap0", gl_cyc[1] - gl_cyc[0], 12);
            chk("t6_gap1", gl_cyc[2] - gl_cyc[1], 12);
            chk("t6_len", dl_cyc[0] - gl_cyc[0], 11);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin : watchdog
        #500000;
        n_vec++; n_miss++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
